vga_timing_gen: RTL

Generates 640x480@60 Hz VGA timing from the 100 MHz `mclk` and drives the board's `Hsync`, `Vsync`, `OutRed`, `OutGreen`, `OutBlue` and `Led` pins. It sits directly upstream of the VGA connector and is instantiated by `top`. The pixel source, such as a framebuffer or character generator, sits upstream of this block: it receives pixel coordinates and returns one RGB332 byte per pixel. The block blanks and aligns that byte to the sync pulses.

---
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Purpose  : 640x480@60 Hz VGA timing generator. It divides mclk down to the
//            pixel rate and produces pixel coordinates plus a request flag for
//            an upstream pixel source. One pixel period later it drives the
//            returned RGB332 byte to the pins, blanked and aligned with the
//            registered sync pulses.
// Ports    : mclk         in   system clock (100 MHz)
//            rst_n        in   asynchronous active-low reset
//            pix_x/pix_y  out  coordinates of the pixel being requested
//            pix_req      out  requested pixel lies in the active area
//            pix_data     in   RGB332 pixel: [7:5] R, [4:2] G, [1:0] B
//            pix_tick     out  one-mclk strobe marking each pixel period
//            frame_start  out  strobe on the tick that requests pixel (0,0)
//            Hsync/Vsync  out  sync outputs, active low
//            OutRed/OutGreen/OutBlue  out  colour pins (blue is [2:1])
//            Led          out  toggles once per frame
// Options  : VGA_TESTPAT_EN - when defined, pix_data is ignored and active
//            pixels show eight vertical colour bars.
// Revision : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
  parameter int CLK_DIV = 4,   // mclk cycles per pixel, legal 2..16
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       mclk,
  input  logic       rst_n,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_req,
  input  logic [7:0] pix_data,
  output logic       pix_tick,
  output logic       frame_start,
  output logic       Hsync,
  output logic       Vsync,
  output logic [2:0] OutRed,
  output logic [2:0] OutGreen,
  output logic [2:1] OutBlue,
  output logic       Led
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT_W  = 10'(H_ACT);
  localparam logic [9:0] V_ACT_W  = 10'(V_ACT);
  localparam logic [9:0] HS_BEG   = 10'(H_ACT + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACT + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG   = 10'(V_ACT + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACT + V_FP + V_SYNC);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       led_q, led_d;
  logic [7:0] rgb_q, rgb_d;

  logic       hs_raw;
  logic       vs_raw;
  logic [7:0] pix_src;

  // Request side: combinational from the counters.
  assign pix_tick    = (div_cnt_q == DIV_LAST);
  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign pix_req     = (h_cnt_q < H_ACT_W) && (v_cnt_q < V_ACT_W);
  assign frame_start = pix_tick && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

  assign hs_raw = !((h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END));
  assign vs_raw = !((v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END));

`ifdef VGA_TESTPAT_EN
  // Eight equal-width bars across the active width (80 px at 640).
  localparam logic [9:0] BAR_W = 10'(H_ACT / 8);

  logic [9:0] bar_idx;

  assign bar_idx = h_cnt_q / BAR_W;

  always_comb begin
    case (bar_idx)
      10'd0:   pix_src = 8'hFF;  // white
      10'd1:   pix_src = 8'hFC;  // yellow
      10'd2:   pix_src = 8'h1F;  // cyan
      10'd3:   pix_src = 8'h1C;  // green
      10'd4:   pix_src = 8'hE3;  // magenta
      10'd5:   pix_src = 8'hE0;  // red
      10'd6:   pix_src = 8'h03;  // blue
      default: pix_src = 8'h00;  // black
    endcase
  end
`else
  assign pix_src = pix_data;
`endif

  always_comb begin
    div_cnt_d = pix_tick ? 4'd0 : div_cnt_q + 4'd1;
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    hsync_d   = hsync_q;
    vsync_d   = vsync_q;
    rgb_d     = rgb_q;
    led_d     = led_q;

    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = 10'd0;
        v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
      // Output stage: syncs and colour for the pixel requested this period
      // leave together on the same edge.
      hsync_d = hs_raw;
      vsync_d = vs_raw;
      rgb_d   = pix_req ? pix_src : 8'h00;
    end

    if (frame_start) begin
      led_d = ~led_q;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= 4'd0;
      h_cnt_q   <= 10'd0;
      v_cnt_q   <= 10'd0;
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      rgb_q     <= 8'h00;
      led_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      rgb_q     <= rgb_d;
      led_q     <= led_d;
    end
  end

  assign Hsync    = hsync_q;
  assign Vsync    = vsync_q;
  assign OutRed   = rgb_q[7:5];
  assign OutGreen = rgb_q[4:2];
  assign OutBlue  = rgb_q[1:0];
  assign Led      = led_q;

endmodule
`default_nettype wire
